// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive front end: rx synchroniser, start-edge detector, per-bit clock counter
// and 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic run_i,
    output logic start_edge_o,
    output logic sample_valid_o,
    output logic sample_bit_o,
    output logic bit_end_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE_A = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE_B = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);

    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_d_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       vote_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!run_i || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    // fill_q keeps rx_d low until rx_s holds a real line sample, so the idle
    // reset value of the synchroniser can never masquerade as a seen-high line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= UART_IDLE_LEVEL;
            rx_s_q    <= UART_IDLE_LEVEL;
            rx_d_q    <= 1'b0;
            fill_q    <= 2'b00;
            cnt_q     <= '0;
            vote_q    <= 2'b00;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
            rx_d_q    <= rx_s_q & fill_q[1];
            cnt_q     <= cnt_d;
            if (run_i && cnt_q == CNT_VOTE_A) begin
                vote_q[0] <= rx_s_q;
            end
            if (run_i && cnt_q == CNT_VOTE_B) begin
                vote_q[1] <= rx_s_q;
            end
        end
    end

    assign start_edge_o   = rx_d_q & ~rx_s_q;
    assign sample_valid_o = run_i && (cnt_q == CNT_DECIDE);
    assign sample_bit_o   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    assign bit_end_o      = run_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start validation, LSB-first data assembly and stop-bit
// check, with single-cycle strobes for start, good byte and framing error.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  rx_ready,
    output logic                  rx_new_byte_started,
    output logic                  rx_new_byte_received,
    output logic [DATA_WIDTH-1:0] byteFromRx,
    output logic                  frame_error
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_cpb_check
            $fatal(1, "uart_rx_frame: CLKS_PER_BIT must be at least 8");
        end
    endgenerate

    uart_rx_state_t        state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic                  started_q, started_d;
    logic                  received_q, received_d;
    logic                  ferr_q, ferr_d;
    logic                  ready_q;

    logic start_edge;
    logic sample_valid;
    logic sample_bit;
    logic bit_end;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk           (clk),
        .rst           (rst),
        .rx_i          (rx),
        .run_i         (state_q != IDLE),
        .start_edge_o  (start_edge),
        .sample_valid_o(sample_valid),
        .sample_bit_o  (sample_bit),
        .bit_end_o     (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            started_q  <= 1'b0;
            received_q <= 1'b0;
            ferr_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            started_q  <= started_d;
            received_q <= received_d;
            ferr_q     <= ferr_d;
            ready_q    <= (state_d == IDLE);
        end
    end

    // STOP leaves at the mid-bit decision so a back-to-back start edge is caught.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_valid && sample_bit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        byte_d     = byte_q;
        started_d  = 1'b0;
        received_d = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            START: begin
                if (sample_valid && !sample_bit) begin
                    started_d = 1'b1;
                end
            end
            DATA: begin
                if (sample_valid) begin
                    shift_d[idx_q] = sample_bit;
                end
            end
            STOP: begin
                if (sample_valid) begin
                    if (sample_bit) begin
                        byte_d     = shift_q;
                        received_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_ready             = ready_q;
    assign rx_new_byte_started  = started_q;
    assign rx_new_byte_received = received_q;
    assign byteFromRx           = byte_q;
    assign frame_error          = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 10 clocks per bit: reset, single frame,
// glitch, framing error, back-to-back frames and mid-frame reset.
module tb_uart_rx_frame;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_ready;
    logic       rx_new_byte_started;
    logic       rx_new_byte_received;
    logic [7:0] byteFromRx;
    logic       frame_error;

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int started_cnt = 0;
    int recv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int recv_cyc = 0;
    logic [7:0] rx_bytes[$];

    uart_rx_frame #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (5_000_000),
        .DATA_WIDTH(8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx                  (rx),
        .rx_ready            (rx_ready),
        .rx_new_byte_started (rx_new_byte_started),
        .rx_new_byte_received(rx_new_byte_received),
        .byteFromRx          (byteFromRx),
        .frame_error         (frame_error)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_new_byte_started) started_cnt <= started_cnt + 1;
        if (rx_new_byte_received) begin
            recv_cnt <= recv_cnt + 1;
            recv_cyc <= cyc;
            rx_bytes.push_back(byteFromRx);
        end
        if (frame_error) err_cnt <= err_cnt + 1;
        if (frame_error && rx_new_byte_received) both_cnt <= both_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    initial begin
        int t0;
        logic ready_seen;

        // 1: reset with idle line, then reset with line held low
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_ready", 32'(rx_ready), 32'd1);
        check("reset_byte", 32'(byteFromRx), 32'h0);
        check("reset_pulses", {29'b0, rx_new_byte_started, rx_new_byte_received, frame_error}, 32'h0);
        $display("step reset: ready=%0d byte=0x%02h", rx_ready, byteFromRx);

        rst = 1'b1;
        rx  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        check("low_after_reset_no_start", 32'(started_cnt), 32'd0);
        check("low_after_reset_ready", 32'(rx_ready), 32'd1);
        $display("step low-line after reset: started=%0d ready=%0d", started_cnt, rx_ready);
        idle(10);

        // 2: single good frame 0xA5 with latency check
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_started", 32'(started_cnt), 32'd1);
        check("a5_received", 32'(recv_cnt), 32'd1);
        check("a5_byte", 32'(byteFromRx), 32'hA5);
        check("a5_ferr", 32'(err_cnt), 32'd0);
        check("a5_latency", 32'(recv_cyc - t0), 32'd100);
        $display("frame 0xA5: byte=0x%02h received=%0d latency=%0d", byteFromRx, recv_cnt, recv_cyc - t0);

        // 3: start glitch of 3 cycles
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        check("glitch_busy", 32'(rx_ready), 32'd0);
        ready_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rx_ready) begin
                ready_seen = 1'b1;
                break;
            end
        end
        check("glitch_ready_back", 32'(ready_seen), 32'd1);
        idle(20);
        check("glitch_pulses", {started_cnt[7:0], recv_cnt[7:0], err_cnt[7:0], 8'h0}, {8'd1, 8'd1, 8'd0, 8'h0});
        $display("glitch: ready_back=%0d started=%0d received=%0d errors=%0d", ready_seen, started_cnt, recv_cnt, err_cnt);

        // 4: framing error on 0x3C
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("ferr_count", 32'(err_cnt), 32'd1);
        check("ferr_byte_held", 32'(byteFromRx), 32'hA5);
        check("ferr_no_received", 32'(recv_cnt), 32'd1);
        $display("frame 0x3C stop=0: errors=%0d byte=0x%02h", err_cnt, byteFromRx);

        // 5: back-to-back frames
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(20);
        check("b2b_received", 32'(recv_cnt), 32'd4);
        check("b2b_started", 32'(started_cnt), 32'd5);
        check("b2b_byte0", 32'(rx_bytes[1]), 32'h00);
        check("b2b_byte1", 32'(rx_bytes[2]), 32'hFF);
        check("b2b_byte2", 32'(rx_bytes[3]), 32'h55);
        $display("back-to-back: received=%0d last=0x%02h", recv_cnt, byteFromRx);

        // 6: reset during data bit 4, then a clean 0x81
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            repeat (CPB) tick();
        end
        rx = 1'b0;
        repeat (5) tick();
        check("abort_busy", 32'(rx_ready), 32'd0);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        idle(30);
        check("abort_no_received", 32'(recv_cnt), 32'd4);
        check("abort_no_ferr", 32'(err_cnt), 32'd1);
        check("abort_byte_reset", 32'(byteFromRx), 32'h0);
        check("abort_ready", 32'(rx_ready), 32'd1);
        $display("mid-frame reset: received=%0d errors=%0d byte=0x%02h", recv_cnt, err_cnt, byteFromRx);

        send_frame(8'h81, 1'b1);
        idle(20);
        check("post_abort_received", 32'(recv_cnt), 32'd5);
        check("post_abort_byte", 32'(byteFromRx), 32'h81);
        check("exclusive_pulses", 32'(both_cnt), 32'd0);
        $display("frame 0x81: byte=0x%02h received=%0d", byteFromRx, recv_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
